// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared core widths and the issue queue entry type
package mmm_pkg;

  // Architectural widths shared across the front end.
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int HLEN = 8;

  // Default number of issue queue entries.
  localparam int IQ_DEPTH = 8;

  // One buffered instruction with the prediction metadata fetch attached to it.
  typedef struct packed {
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - instruction FIFO between fetch and decode with flush
module issue_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ILEN-1:0]          instruction_i,
  input  logic [XLEN-1:0]          pred_pc_i,
  input  logic [HLEN-1:0]          pred_index_i,
  input  logic [XLEN-1:0]          pred_target_i,
  input  logic                     pred_taken_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ILEN-1:0]          instruction_o,
  output logic [XLEN-1:0]          pred_pc_o,
  output logic [HLEN-1:0]          pred_index_o,
  output logic [XLEN-1:0]          pred_target_o,
  output logic                     pred_taken_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;

  iq_entry_t     mem_q [DEPTH];
  iq_entry_t     entry_in;
  iq_entry_t     head_entry;

  logic          push;
  logic          pop;

  // Readiness and validity come only from registered occupancy, so ready_i never
  // reaches issue_ready_o combinationally and pushes are never visible the same cycle.
  assign issue_ready_o = (count_q != FULL_COUNT);
  assign valid_o       = (count_q != '0);
  assign count_o       = count_q;

  assign push = issue_valid_i && issue_ready_o;
  assign pop  = valid_o && ready_i;

  assign entry_in = '{
    instruction: instruction_i,
    pc:          pred_pc_i,
    index:       pred_index_i,
    target:      pred_target_i,
    taken:       pred_taken_i
  };

  assign head_entry    = mem_q[head_q];
  assign instruction_o = head_entry.instruction;
  assign pred_pc_o     = head_entry.pc;
  assign pred_index_o  = head_entry.index;
  assign pred_target_o = head_entry.target;
  assign pred_taken_o  = head_entry.taken;

  // Pointer and occupancy bookkeeping; flush discards everything including this cycle's handshakes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is deliberately not reset; outputs are only meaningful while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[tail_q] <= entry_in;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - scoreboard bench for issue_queue against a queue model
module tb_issue_queue;
  import mmm_pkg::*;

  localparam int DEPTH = 8;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [ILEN-1:0] instruction_in;
  logic [XLEN-1:0] pc_in;
  logic [HLEN-1:0] index_in;
  logic [XLEN-1:0] target_in;
  logic            taken_in;
  logic            valid;
  logic            ready;
  logic [ILEN-1:0] instruction_out;
  logic [XLEN-1:0] pc_out;
  logic [HLEN-1:0] index_out;
  logic [XLEN-1:0] target_out;
  logic            taken_out;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: the ordered list of entries decode should still receive, plus occupancy.
  iq_entry_t exp_q[$];
  int        model_count = 0;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .instruction_i (instruction_in),
    .pred_pc_i     (pc_in),
    .pred_index_i  (index_in),
    .pred_target_i (target_in),
    .pred_taken_i  (taken_in),
    .valid_o       (valid),
    .ready_i       (ready),
    .instruction_o (instruction_out),
    .pred_pc_o     (pc_out),
    .pred_index_o  (index_out),
    .pred_target_o (target_out),
    .pred_taken_o  (taken_out),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, let the edge happen, then advance the model by the same rules.
  task automatic step(input logic iv, input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
    iq_entry_t ent;
    logic push_f, pop_f;
    ent.instruction = $urandom;
    ent.pc          = pc;
    ent.index       = HLEN'($urandom);
    ent.target      = $urandom;
    ent.taken       = 1'($urandom);
    issue_valid    = iv;
    instruction_in = ent.instruction;
    pc_in          = ent.pc;
    index_in       = ent.index;
    target_in      = ent.target;
    taken_in       = ent.taken;
    ready          = rdy;
    flush          = fl;
    @(posedge clk);
    push_f = iv && (model_count != DEPTH);
    pop_f  = rdy && (model_count != 0);
    if (fl) begin
      model_count = 0;
      exp_q.delete();
    end else begin
      if (push_f) exp_q.push_back(ent);
      model_count = model_count + int'(push_f) - int'(pop_f);
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (model_count != 0 && n < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", 64'(model_count), 64'd0);
  endtask

  // Monitor: compares status against the model and pops the scoreboard on each decode handshake.
  always @(negedge clk) begin
    iq_entry_t e;
    if (rst_n) begin
      check("count", 64'(count), 64'(model_count));
      check("valid", 64'(valid), 64'(model_count != 0));
      check("issue_ready", 64'(issue_ready), 64'(model_count != DEPTH));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %0h expected no entry", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("pop_instruction", 64'(instruction_out), 64'(e.instruction));
          check("pop_pc", 64'(pc_out), 64'(e.pc));
          check("pop_index", 64'(index_out), 64'(e.index));
          check("pop_target", 64'(target_out), 64'(e.target));
          check("pop_taken", 64'(taken_out), 64'(e.taken));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] pc;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; ready = 1'b0;
    instruction_in = '0; pc_in = '0; index_in = '0; target_in = '0; taken_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    check("reset_count", 64'(count), 64'd0);
    rst_n = 1'b1;

    // Three pushes with decode stalled; head is the first one.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("first_valid_latency", 64'(valid), 64'd1);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b0);
    check("three_count", 64'(count), 64'd3);
    check("three_head_pc", 64'(pc_out), 64'h100);
    step(1'b0, '0, 1'b0, 1'b1);

    // Fill to full, then push refused while a pop completes.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    check("full_issue_ready", 64'(issue_ready), 64'd0);
    step(1'b1, 32'h900, 1'b1, 1'b0);
    check("full_pop_count", 64'(count), 64'd7);
    check("full_pop_ready", 64'(issue_ready), 64'd1);
    check("full_pop_head", 64'(pc_out), 64'h4);
    drain();

    // Continuous stream across pointer wrap-around.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd1);
    end
    drain();

    // Flush with a simultaneous push discards everything.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    check("prefill_count", 64'(count), 64'd5);
    step(1'b1, 32'h3ff, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(valid), 64'd0);
    check("flush_issue_ready", 64'(issue_ready), 64'd1);
    step(1'b1, 32'h200, 1'b0, 1'b0);
    check("post_flush_head", 64'(pc_out), 64'h200);
    drain();

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
    issue_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_issue_ready", 64'(issue_ready), 64'd1);
    model_count = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic against the scoreboard.
    pc = '0;
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom), pc, 1'($urandom), 1'b0);
      pc = pc + 32'd4;
      check("count_bound", 64'(count <= DEPTH), 64'd1);
    end
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Instruction FIFO between fetch_stage (producer) and instruction decode (consumer).
- Buffers each fetched instruction together with its branch-prediction metadata (pc, history index, predicted target, taken flag).
- Decouples fetch from decode stalls and discards all in-flight entries on a pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; empties the queue.
- issue_valid_i  in  1  fetch presents an instruction.
- issue_ready_o  out  1  queue can accept a push (drives fetch_stage issue_ready_i).
- instruction_i  in  ILEN  instruction word.
- pred_pc_i  in  XLEN  pc of the instruction.
- pred_index_i  in  HLEN  predictor history index.
- pred_target_i  in  XLEN  predicted target.
- pred_taken_i  in  1  predicted taken.
- valid_o  out  1  head entry valid toward decode.
- ready_i  in  1  decode accepts the head entry.
- instruction_o  out  ILEN  head instruction.
- pred_pc_o  out  XLEN  head pc.
- pred_index_o  out  HLEN  head history index.
- pred_target_o  out  XLEN  head predicted target.
- pred_taken_o  out  1  head predicted taken.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH iq_entry_t entries.
  - head_q and tail_q pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count_q is $clog2(DEPTH)+1 bits.
- Reset (rst_n_i low, asynchronous):
  - head_q = tail_q = 0, count_q = 0.
  - Outputs: valid_o = 0, issue_ready_o = 1, count_o = 0.
  - Storage array is not reset. Data outputs are don't-care while valid_o = 0.
- Push: fires when issue_valid_i && issue_ready_o. Writes the entry at tail_q, then tail_q++.
- Pop: fires when valid_o && ready_i. head_q++.
- Readiness and validity:
  - issue_ready_o = (count_q != DEPTH), a pure function of registered state.
  - There is no combinational path from ready_i to issue_ready_o.
  - valid_o = (count_q != 0). Data outputs are driven from entry[head_q]; there is no fall-through.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at any non-empty, non-full occupancy.
- Full: push is refused even if a pop occurs in the same cycle, because issue_ready_o is 0. The pop still completes.
- Empty: pop impossible (valid_o = 0). A push in the empty cycle is not visible until the next cycle.
- Flush (flush_i high at a rising edge):
  - head_q, tail_q and count_q clear to 0.
  - Any push or pop in that cycle is discarded/ignored.
  - Next cycle: valid_o = 0 and issue_ready_o = 1.
  - Flush has priority over push and pop.
- Invariant: count_q = (tail_q - head_q) mod DEPTH, except count_q = DEPTH when the pointers are equal and the queue is full.
- Handshake rule: the producer must hold instruction_i and pred_* stable while issue_valid_i && !issue_ready_o. The queue does not check this.

Decomposition:
- mmm_pkg additions:
  - iq_entry_t packed struct {instruction ILEN, pc XLEN, index HLEN, target XLEN, taken 1}.
  - IQ_DEPTH constant (default 8), used as the DEPTH default.
- XLEN, ILEN and HLEN already live in mmm_pkg.
- No sub-module: pointer/count logic and the storage array fit in one module.

Test Plan (DEPTH = 8):
- Reset then push 3 entries with pc = 0x100, 0x104, 0x108 and ready_i = 0 -> count_o = 3, valid_o = 1, pred_pc_o = 0x100. First valid_o is one cycle after the first push.
- Push 8 entries with ready_i = 0 -> issue_ready_o = 0 after the 8th. A 9th with issue_valid_i = 1 and ready_i = 1 in the same cycle -> pop of entry 0 completes, 9th not stored, count_o = 7. issue_ready_o = 1 the next cycle.
- Continuous push and pop for 20 cycles with pc incrementing by 4 from 0x0 -> count_o constant at 1 after the first cycle. Decode receives 0x0..0x4C in order with pred_taken/target/index intact across pointer wrap-around.
- Fill to 5, assert flush_i with a simultaneous push -> next cycle count_o = 0, valid_o = 0, issue_ready_o = 1. A subsequent push of pc 0x200 appears as the head.
- Assert rst_n_i low mid-operation at count 4, asynchronous to the clock edge -> valid_o = 0 and count_o = 0 immediately, before the next edge.
- Random issue_valid_i/ready_i (50%) over 1000 cycles against a scoreboard -> no loss, no duplication, order preserved, count_o never > 8.
